// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter.
//   arb_state_e : lock ownership state (IDLE, OWN0, OWN1)
//   M0 / M1     : master index constants used for grant/valid vectors
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int M0 = 0;
  localparam int M1 = 1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter.
//   req/addr/wdata/we/lock : request side, driven by the master
//   gnt                    : access issued this cycle
//   rvalid/rdata           : registered read return, cycle after a read grant
// modport master : seen from the requester
// modport slave  : seen from the arbiter
interface dmem_arbiter_if;
  logic        req;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  we;
  logic        lock;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, addr, wdata, we, lock,
                  input  gnt, rvalid, rdata);
  modport slave  (input  req, addr, wdata, we, lock,
                  output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arb_rr.sv
// Combinational round-robin grant with lock ownership.
//   req   : request vector, bit index = master
//   state : current lock owner (IDLE, OWN0, OWN1)
//   last  : index of the most recently granted master
//   gnt   : one-hot grant vector (or zero)
module dmem_arb_rr
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  arb_state_e state,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (state == OWN0 && req[M0]) begin
      gnt[M0] = 1'b1;
    end else if (state == OWN1 && req[M1]) begin
      gnt[M1] = 1'b1;
    end else if (req[M0] && req[M1]) begin
      // tie goes to whichever master was not served last
      if (last) gnt[M0] = 1'b1;
      else      gnt[M1] = 1'b1;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port 16 KB data memory.
//   clk, reset      : clock, synchronous active-high reset
//   m0, m1          : requester ports (CPU load/store, DMA/debug loader)
//   daddr/dwdata/dwe: access issued to the memory this cycle
//   drdata          : asynchronous read data from the memory
//
//   state | meaning
//   IDLE  | no lock owner, round-robin between requesters
//   OWN0  | m0 holds the lock and wins while it requests
//   OWN1  | m1 holds the lock and wins while it requests
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_LOCK  = 8,
  parameter bit LAST_INIT = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [31:0]       daddr,
  output logic [31:0]       dwdata,
  output logic [3:0]        dwe,
  input  logic [31:0]       drdata
);

  localparam logic [8:0] MAX_LOCK_W = 9'(MAX_LOCK);

  arb_state_e  state_q, state_d;
  logic        last_q, last_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;

  logic [1:0]  req, gnt_raw, gnt;
  logic        win, win_lock, same_owner;
  logic [8:0]  run_len;

  assign req = {m1.req, m0.req};

  dmem_arb_rr u_rr (
    .req   (req),
    .state (state_q),
    .last  (last_q),
    .gnt   (gnt_raw)
  );

  assign gnt    = reset ? 2'b00 : gnt_raw;
  assign m0.gnt = gnt[M0];
  assign m1.gnt = gnt[M1];

  always_comb begin
    daddr  = '0;
    dwdata = '0;
    dwe    = '0;
    if (gnt[M0]) begin
      daddr  = m0.addr;
      dwdata = m0.wdata;
      dwe    = m0.we;
    end else if (gnt[M1]) begin
      daddr  = m1.addr;
      dwdata = m1.wdata;
      dwe    = m1.we;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    win        = gnt[M1];
    win_lock   = win ? m1.lock : m0.lock;
    same_owner = (state_q == OWN0 && !win) || (state_q == OWN1 && win);
    // a grant that continues the current owner's run extends it, any other starts at 1
    run_len    = same_owner ? {1'b0, lock_cnt_q} + 9'd1 : 9'd1;
    if (gnt == 2'b00) begin
      state_d    = IDLE;
      lock_cnt_d = '0;
    end else begin
      last_d = win;
      if (win_lock && run_len < MAX_LOCK_W) begin
        state_d    = win ? OWN1 : OWN0;
        lock_cnt_d = run_len[7:0];
      end else begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    end
  end

  always_comb begin
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (gnt[M0] && m0.we == 4'b0000) begin
      rvalid_d[M0] = 1'b1;
      rdata0_d     = drdata;
    end
    if (gnt[M1] && m1.we == 4'b0000) begin
      rvalid_d[M1] = 1'b1;
      rdata1_d     = drdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= LAST_INIT;
      lock_cnt_q <= '0;
      rvalid_q   <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rvalid_q   <= rvalid_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign m0.rvalid = rvalid_q[M0];
  assign m1.rvalid = rvalid_q[M1];
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

endmodule
